// File: rtl/muldiv_pkg.sv
// Shared multiply/divide definitions: FSM encoding, default latency and the
// width of the latency down-counter.
package muldiv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mul_state_e;

  localparam int MULT_LAT_DEFAULT = 4;
  localparam int MULT_LAT_MAX     = 15;
  localparam int MULT_CNT_W       = $clog2(MULT_LAT_MAX + 1);

endpackage

// File: rtl/mult_hilo_ctrl_if.sv
// EX-stage side of the HI/LO multiply controller: request, move and
// read-hazard inputs, plus the stall/busy/done status and the HI/LO pair.
interface mult_hilo_ctrl_if;

  logic        start;
  logic        sign;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        mf_req;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, sign, op_a, op_b, mthi, mtlo, wdata, mf_req, flush,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, sign, op_a, op_b, mthi, mtlo, wdata, mf_req, flush,
    output busy, stall, done, hi, lo
  );

endinterface

// File: rtl/mult_hilo_ctrl_mult.sv
// 32x32 MULT/MULTU array: operands are extended by the sign bit (or zero)
// and the low 64 bits of the product are returned.
module mult_hilo_ctrl_mult (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sign,
  output logic [63:0] z
);

  logic [63:0] a_ext;
  logic [63:0] b_ext;

  // The low 64 bits of a product do not depend on signedness once the
  // operands are extended to 64 bits, so one unsigned multiply serves both.
  assign a_ext = {{32{sign & a[31]}}, a};
  assign b_ext = {{32{sign & b[31]}}, b};
  assign z     = a_ext * b_ext;

endmodule

// File: rtl/mult_hilo_ctrl.sv
// HI/LO owner beside EX: runs one MULT/MULTU at a time with a fixed latency,
// handles MTHI/MTLO, and raises the pipeline stall on HI/LO hazards.
module mult_hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int LATENCY = MULT_LAT_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  mult_hilo_ctrl_if.slave ex
);

  localparam logic [MULT_CNT_W-1:0] CNT_LOAD = MULT_CNT_W'(LATENCY - 1);

  mul_state_e            state_q, state_d;
  logic [MULT_CNT_W-1:0] count_q, count_d;
  logic                  sign_q;
  logic [31:0]           a_q, b_q;
  logic [31:0]           hi_q, lo_q;
  logic                  done_q;
  logic [63:0]           product;

  logic busy;
  logic stall;
  logic accept_start;
  logic accept_hi;
  logic accept_lo;
  logic finish;

  assign busy  = (state_q == RUN);
  assign stall = busy & (ex.start | ex.mf_req | ex.mthi | ex.mtlo) & ~ex.flush;

  // flush outranks everything; stalled ops are re-presented by the pipeline.
  assign accept_start = ex.start & ~stall & ~ex.flush;
  assign accept_hi    = ex.mthi  & ~stall & ~ex.flush;
  assign accept_lo    = ex.mtlo  & ~stall & ~ex.flush;

  mult_hilo_ctrl_mult u_mult (
    .a    (a_q),
    .b    (b_q),
    .sign (sign_q),
    .z    (product)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    count_d = count_q;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept_start) begin
          state_d = RUN;
          count_d = CNT_LOAD;
        end
      end
      RUN: begin
        if (ex.flush) begin
          state_d = IDLE;
        end else if (count_q == '0) begin
          finish  = 1'b1;
          state_d = IDLE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      // NOTE: the latched operands are reset too, so the multiplier never
      // sees X after reset even though its output is unused in IDLE.
      sign_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= finish;
      if (accept_start) begin
        sign_q <= ex.sign;
        a_q    <= ex.op_a;
        b_q    <= ex.op_b;
      end
      // A move accepted with a start writes now; the product overwrites later.
      if (finish) begin
        hi_q <= product[63:32];
        lo_q <= product[31:0];
      end else begin
        if (accept_hi) hi_q <= ex.wdata;
        if (accept_lo) lo_q <= ex.wdata;
      end
    end
  end

  assign ex.busy  = busy;
  assign ex.stall = stall;
  assign ex.done  = done_q;
  assign ex.hi    = hi_q;
  assign ex.lo    = lo_q;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Self-checking bench for mult_hilo_ctrl: directed scenarios plus randomized
// multiplies/moves/flushes checked against an arithmetic HI/LO model.
module tb_mult_hilo_ctrl;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mult_hilo_ctrl_if bus4 ();
  mult_hilo_ctrl_if bus1 ();

  mult_hilo_ctrl #(.LATENCY(LAT)) dut4 (.clk(clk), .rst(rst), .ex(bus4));
  mult_hilo_ctrl #(.LATENCY(1))   dut1 (.clk(clk), .rst(rst), .ex(bus1));

  // Reference product straight from the MULT/MULTU definition.
  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'h0, a};
    ub = {32'h0, b};
    return ua * ub;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus4.start = 1'b0; bus4.sign = 1'b0; bus4.op_a = '0; bus4.op_b = '0;
    bus4.mthi = 1'b0; bus4.mtlo = 1'b0; bus4.wdata = '0; bus4.mf_req = 1'b0; bus4.flush = 1'b0;
    bus1.start = 1'b0; bus1.sign = 1'b0; bus1.op_a = '0; bus1.op_b = '0;
    bus1.mthi = 1'b0; bus1.mtlo = 1'b0; bus1.wdata = '0; bus1.mf_req = 1'b0; bus1.flush = 1'b0;
  endtask

  // Accepts one multiply on bus4 and follows it edge by edge to completion.
  task automatic run_mult(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string name);
    logic [31:0] old_hi, old_lo;
    old_hi = bus4.hi;
    old_lo = bus4.lo;
    bus4.start = 1'b1; bus4.sign = s; bus4.op_a = a; bus4.op_b = b;
    tick();
    bus4.start = 1'b0; bus4.sign = ~s; bus4.op_a = $urandom; bus4.op_b = $urandom;
    for (int k = 1; k <= LAT; k++) begin
      n_checks++;
      if ({bus4.busy, bus4.done, bus4.hi, bus4.lo} !== {1'b1, 1'b0, old_hi, old_lo}) begin
        n_fail++;
        $display("FAIL %s_run%0d: busy/done/hi/lo got %h expected %h", name, k,
                 {bus4.busy, bus4.done, bus4.hi, bus4.lo}, {1'b1, 1'b0, old_hi, old_lo});
      end
      tick();
    end
    n_checks++;
    if ({bus4.busy, bus4.done, bus4.hi, bus4.lo} !== {1'b0, 1'b1, exp}) begin
      n_fail++;
      $display("FAIL %s_result: busy/done/hi/lo got %h expected %h", name,
               {bus4.busy, bus4.done, bus4.hi, bus4.lo}, {1'b0, 1'b1, exp});
    end
    tick();
    n_checks++;
    if (bus4.done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_pulse: done got %b expected 0", name, bus4.done);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus4.busy, bus4.done, bus4.stall, bus4.hi, bus4.lo} !== 67'h0) begin
      n_fail++;
      $display("FAIL reset_dut4: got %h expected 0", {bus4.busy, bus4.done, bus4.stall, bus4.hi, bus4.lo});
    end
    n_checks++;
    if ({bus1.busy, bus1.done, bus1.stall, bus1.hi, bus1.lo} !== 67'h0) begin
      n_fail++;
      $display("FAIL reset_dut1: got %h expected 0", {bus1.busy, bus1.done, bus1.stall, bus1.hi, bus1.lo});
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mult_signed();
    run_mult(1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, "mult_neg3x5");
  endtask

  task automatic test_mult_extremes();
    run_mult(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max");
    run_mult(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "mult_m1xm1");
  endtask

  task automatic test_mf_stall();
    int stalls = 0;
    bus4.mf_req = 1'b1;
    #1;
    n_checks++;
    if (bus4.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL mf_idle_stall: stall got %b expected 0", bus4.stall);
    end
    bus4.mf_req = 1'b0;
    bus4.start = 1'b1; bus4.sign = 1'b0; bus4.op_a = 32'h1234; bus4.op_b = 32'h10;
    tick();
    bus4.start = 1'b0;
    bus4.mf_req = 1'b1;
    for (int k = 0; k <= LAT; k++) begin
      #1;
      n_checks++;
      if (bus4.stall !== (k < LAT)) begin
        n_fail++;
        $display("FAIL mf_stall_cycle%0d: stall got %b expected %b", k, bus4.stall, k < LAT);
      end
      if (bus4.stall === 1'b1) stalls++;
      if (k == LAT) begin
        n_checks++;
        if ({bus4.hi, bus4.lo} !== 64'h0000_0000_0001_2340) begin
          n_fail++;
          $display("FAIL mf_stall_data: hi/lo got %h expected 0000000000012340", {bus4.hi, bus4.lo});
        end
      end
      tick();
    end
    bus4.mf_req = 1'b0;
    n_checks++;
    if (stalls != LAT) begin
      n_fail++;
      $display("FAIL mf_stall_count: stall cycles got %0d expected %0d", stalls, LAT);
    end
  endtask

  task automatic test_flush();
    logic seen_done = 1'b0;
    bus4.mthi = 1'b1; bus4.mtlo = 1'b1; bus4.wdata = 32'hA5A5_A5A5;
    tick();
    bus4.mthi = 1'b0; bus4.mtlo = 1'b0;
    n_checks++;
    if ({bus4.hi, bus4.lo} !== 64'hA5A5_A5A5_A5A5_A5A5) begin
      n_fail++;
      $display("FAIL dual_move: hi/lo got %h expected a5a5a5a5a5a5a5a5", {bus4.hi, bus4.lo});
    end
    // A start killed in its own cycle must never be accepted.
    bus4.start = 1'b1; bus4.flush = 1'b1; bus4.op_a = 32'd7; bus4.op_b = 32'd9;
    tick();
    bus4.start = 1'b0; bus4.flush = 1'b0;
    n_checks++;
    if (bus4.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_start_idle: busy got %b expected 0", bus4.busy);
    end
    bus4.start = 1'b1; bus4.sign = 1'b0;
    tick();
    bus4.start = 1'b0;
    tick();
    bus4.flush = 1'b1; bus4.mf_req = 1'b1;
    #1;
    n_checks++;
    if (bus4.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_masks_stall: stall got %b expected 0", bus4.stall);
    end
    tick();
    bus4.flush = 1'b0; bus4.mf_req = 1'b0;
    n_checks++;
    if (bus4.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_busy: busy got %b expected 0", bus4.busy);
    end
    repeat (LAT + 2) begin
      if (bus4.done === 1'b1) seen_done = 1'b1;
      tick();
    end
    n_checks++;
    if ({seen_done, bus4.hi, bus4.lo} !== {1'b0, 64'hA5A5_A5A5_A5A5_A5A5}) begin
      n_fail++;
      $display("FAIL flush_hold: done_seen/hi/lo got %h expected 0a5a5a5a5a5a5a5a5", {seen_done, bus4.hi, bus4.lo});
    end
  endtask

  task automatic test_back_to_back();
    bus4.start = 1'b1; bus4.sign = 1'b0; bus4.op_a = 32'd10; bus4.op_b = 32'd20;
    tick();
    bus4.op_a = 32'd2; bus4.op_b = 32'd3;
    for (int k = 1; k <= LAT; k++) begin
      n_checks++;
      if ({bus4.busy, bus4.stall} !== 2'b11) begin
        n_fail++;
        $display("FAIL b2b_stall%0d: busy/stall got %b expected 11", k, {bus4.busy, bus4.stall});
      end
      tick();
    end
    n_checks++;
    if ({bus4.busy, bus4.done, bus4.stall, bus4.hi, bus4.lo} !== {3'b010, 64'd200}) begin
      n_fail++;
      $display("FAIL b2b_first: got %h expected %h", {bus4.busy, bus4.done, bus4.stall, bus4.hi, bus4.lo}, {3'b010, 64'd200});
    end
    tick();
    bus4.start = 1'b0;
    n_checks++;
    if (bus4.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_no_dead_cycle: busy got %b expected 1", bus4.busy);
    end
    // A move presented while busy stalls and is dropped by this pipeline.
    bus4.mtlo = 1'b1; bus4.wdata = 32'h99;
    tick();
    bus4.mtlo = 1'b0;
    repeat (LAT - 1) tick();
    n_checks++;
    if ({bus4.done, bus4.hi, bus4.lo} !== {1'b1, 64'd6}) begin
      n_fail++;
      $display("FAIL b2b_second: done/hi/lo got %h expected %h", {bus4.done, bus4.hi, bus4.lo}, {1'b1, 64'd6});
    end
    bus4.mthi = 1'b1; bus4.wdata = 32'h11;
    tick();
    bus4.mthi = 1'b0; bus4.mtlo = 1'b1; bus4.wdata = 32'h22;
    tick();
    bus4.mtlo = 1'b0;
    n_checks++;
    if ({bus4.hi, bus4.lo} !== {32'h11, 32'h22}) begin
      n_fail++;
      $display("FAIL moves: hi/lo got %h expected 0000001100000022", {bus4.hi, bus4.lo});
    end
    bus4.start = 1'b1; bus4.sign = 1'b0; bus4.op_a = 32'd4; bus4.op_b = 32'd5;
    bus4.mthi = 1'b1; bus4.wdata = 32'h77;
    tick();
    bus4.start = 1'b0; bus4.mthi = 1'b0;
    n_checks++;
    if ({bus4.busy, bus4.hi, bus4.lo} !== {1'b1, 32'h77, 32'h22}) begin
      n_fail++;
      $display("FAIL start_move_now: busy/hi/lo got %h expected 10000007700000022", {bus4.busy, bus4.hi, bus4.lo});
    end
    repeat (LAT) tick();
    n_checks++;
    if ({bus4.hi, bus4.lo} !== 64'd20) begin
      n_fail++;
      $display("FAIL start_move_later: hi/lo got %h expected 0000000000000014", {bus4.hi, bus4.lo});
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    logic seen_done = 1'b0;
    bus4.start = 1'b1; bus4.sign = 1'b1; bus4.op_a = 32'hFFFF_FFFD; bus4.op_b = 32'd5;
    tick();
    bus4.start = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus4.busy, bus4.done, bus4.hi, bus4.lo} !== 66'h0) begin
      n_fail++;
      $display("FAIL reset_mid_run: busy/done/hi/lo got %h expected 0", {bus4.busy, bus4.done, bus4.hi, bus4.lo});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 1) begin
      tick();
      if (bus4.done === 1'b1 || bus4.busy === 1'b1) seen_done = 1'b1;
    end
    n_checks++;
    if ({seen_done, bus4.hi, bus4.lo} !== 65'h0) begin
      n_fail++;
      $display("FAIL reset_abort: activity/hi/lo got %h expected 0", {seen_done, bus4.hi, bus4.lo});
    end
    run_mult(1'b0, 32'd123, 32'd456, ref_mul(1'b0, 32'd123, 32'd456), "after_reset");
  endtask

  task automatic test_latency1();
    bus1.start = 1'b1; bus1.sign = 1'b1; bus1.op_a = 32'hFFFF_FFFD; bus1.op_b = 32'd5;
    tick();
    bus1.start = 1'b0; bus1.op_a = '0;
    n_checks++;
    if ({bus1.busy, bus1.done} !== 2'b10) begin
      n_fail++;
      $display("FAIL lat1_run: busy/done got %b expected 10", {bus1.busy, bus1.done});
    end
    tick();
    n_checks++;
    if ({bus1.busy, bus1.done, bus1.hi, bus1.lo} !== {2'b01, 64'hFFFF_FFFF_FFFF_FFF1}) begin
      n_fail++;
      $display("FAIL lat1_result: busy/done/hi/lo got %h expected 1fffffffffffffff1", {bus1.busy, bus1.done, bus1.hi, bus1.lo});
    end
    tick();
  endtask

  task automatic test_random();
    logic [63:0] model;
    logic        h, l, s, seen_done;
    logic [31:0] a, b, w;
    int          cyc, r;
    w = $urandom;
    bus4.mthi = 1'b1; bus4.mtlo = 1'b1; bus4.wdata = w;
    tick();
    bus4.mthi = 1'b0; bus4.mtlo = 1'b0;
    model = {w, w};
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          s = 1'($urandom_range(0, 1)); a = pick_operand(); b = pick_operand();
          bus4.start = 1'b1; bus4.sign = s; bus4.op_a = a; bus4.op_b = b;
          tick();
          bus4.start = 1'b0; bus4.op_a = $urandom; bus4.op_b = $urandom;
          cyc = 1;
          tick();
          while (bus4.done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
          end
          model = ref_mul(s, a, b);
          n_checks++;
          if (cyc != LAT || {bus4.hi, bus4.lo} !== model) begin
            n_fail++;
            $display("FAIL rand%0d_mult: latency %0d hi/lo %h expected latency %0d hi/lo %h",
                     t, cyc, {bus4.hi, bus4.lo}, LAT, model);
          end
          tick();
        end
        2: begin
          h = 1'($urandom_range(0, 1)); l = 1'($urandom_range(0, 1));
          if (!h && !l) h = 1'b1;
          w = $urandom;
          bus4.mthi = h; bus4.mtlo = l; bus4.wdata = w;
          tick();
          bus4.mthi = 1'b0; bus4.mtlo = 1'b0;
          if (h) model[63:32] = w;
          if (l) model[31:0]  = w;
          n_checks++;
          if ({bus4.hi, bus4.lo} !== model) begin
            n_fail++;
            $display("FAIL rand%0d_move: hi/lo got %h expected %h", t, {bus4.hi, bus4.lo}, model);
          end
        end
        default: begin
          r = $urandom_range(0, LAT - 1);
          seen_done = 1'b0;
          bus4.start = 1'b1; bus4.sign = 1'($urandom_range(0, 1));
          bus4.op_a = pick_operand(); bus4.op_b = pick_operand();
          tick();
          bus4.start = 1'b0;
          repeat (r) tick();
          bus4.flush = 1'b1;
          tick();
          bus4.flush = 1'b0;
          n_checks++;
          if (bus4.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rand%0d_flush_busy: busy got %b expected 0 (flush at %0d)", t, bus4.busy, r);
          end
          repeat (LAT) begin
            if (bus4.done === 1'b1) seen_done = 1'b1;
            tick();
          end
          n_checks++;
          if ({seen_done, bus4.hi, bus4.lo} !== {1'b0, model}) begin
            n_fail++;
            $display("FAIL rand%0d_flush_hold: done_seen/hi/lo got %h expected %h", t,
                     {seen_done, bus4.hi, bus4.lo}, {1'b0, model});
          end
        end
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mult_signed();
    test_mult_extremes();
    test_mf_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid_run();
    test_latency1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
